dx_operand_stage: RTL and testbench

- Decode/execute pipeline stage that sits directly upstream of the 32-bit ALU.
- Decodes the incoming instruction and drives register-file read addresses.
- Resolves RAW hazards by forwarding from X, M and W. Inserts a one-cycle bubble on a load-use hazard.
- Registers the final ALU inputs (operand A, operand B, opcode, shift amount) plus control for downstream stages.
- Uses a valid/ready handshake on both input and output.

---
 rtl/dx_operand_stage.sv | 177 +++++++++++++++++
 tb/tb_dx_operand_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dx_operand_stage.sv
// Decode/operand stage feeding the ALU: decodes the instruction, forwards from X/M/W,
// inserts a single bubble on load-use (or on any X dependence when X forwarding is off).
module dx_operand_stage #(
  parameter bit XFWD_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  input  logic [31:0] x_result,
  input  logic        m_wr_en,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  input  logic        w_wr_en,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_is_branch,
  output logic [31:0] out_store_data,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;

  logic [4:0]  f_op, f_rd, f_rs, f_rt, f_sh, f_aop;
  logic [31:0] imm_sext;

  assign f_op     = in_insn[31:27];
  assign f_rd     = in_insn[26:22];
  assign f_rs     = in_insn[21:17];
  assign f_rt     = in_insn[16:12];
  assign f_sh     = in_insn[11:7];
  assign f_aop    = in_insn[6:2];
  assign imm_sext = {{15{in_insn[16]}}, in_insn[16:0]};

  logic        use_a, use_b, dec_imm, dec_wr, dec_ld, dec_st, dec_br;
  logic [4:0]  src_a, src_b, dec_opc, dec_sh;

  always_comb begin
    use_a   = 1'b0;
    use_b   = 1'b0;
    src_a   = f_rs;
    src_b   = f_rt;
    dec_imm = 1'b0;
    dec_opc = 5'd0;
    dec_sh  = 5'd0;
    dec_wr  = 1'b0;
    dec_ld  = 1'b0;
    dec_st  = 1'b0;
    dec_br  = 1'b0;
    case (f_op)
      OP_RTYPE: begin
        use_a = 1'b1; use_b = 1'b1;
        dec_opc = f_aop; dec_sh = f_sh; dec_wr = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_a = 1'b1; dec_imm = 1'b1; dec_wr = 1'b1;
        dec_ld = (f_op == OP_LW);
      end
      OP_SW: begin
        use_a = 1'b1; use_b = 1'b1; src_b = f_rd;
        dec_imm = 1'b1; dec_st = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        use_a = 1'b1; use_b = 1'b1; src_a = f_rd; src_b = f_rs;
        dec_opc = 5'd1; dec_br = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_addr_a = src_a;
  assign rf_addr_b = src_b;

  logic        valid_q, wr_q, ld_q, st_q, br_q;
  logic [31:0] opa_q, opb_q, sd_q, insn_q, pc_q;
  logic [4:0]  opc_q, sh_q, rd_q;

  // X can only supply a value once the ALU has produced it, so loads in X never forward.
  logic x_fwd_ok;
  assign x_fwd_ok = XFWD_EN && valid_q && wr_q && !ld_q;

  function automatic logic [31:0] resolve(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0)                      return 32'd0;
    else if (x_fwd_ok && rd_q == s)     return x_result;
    else if (m_wr_en && m_rd == s)      return m_data;
    else if (w_wr_en && w_rd == s)      return w_data;
    else                                return rf;
  endfunction

  logic [31:0] fwd_a, fwd_b, nxt_opa, nxt_opb;
  assign fwd_a   = resolve(src_a, rf_data_a);
  assign fwd_b   = resolve(src_b, rf_data_b);
  assign nxt_opa = use_a ? fwd_a : 32'd0;
  assign nxt_opb = dec_imm ? imm_sext : (use_b ? fwd_b : 32'd0);

  logic dep_a, dep_b, hazard, load_en;
  assign dep_a   = use_a && src_a != 5'd0 && src_a == rd_q;
  assign dep_b   = use_b && src_b != 5'd0 && src_b == rd_q;
  assign hazard  = in_valid && valid_q && wr_q && (ld_q || !XFWD_EN) && (dep_a || dep_b);
  assign load_en = !valid_q || out_ready;
  assign in_ready = !flush && load_en && !hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      opc_q   <= 5'd0;
      sh_q    <= 5'd0;
      rd_q    <= 5'd0;
      wr_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      br_q    <= 1'b0;
      sd_q    <= 32'd0;
      insn_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load_en) begin
      // A bubble only clears valid; the stale fields are never observed.
      valid_q <= in_valid && !hazard;
      if (in_valid && !hazard) begin
        opa_q  <= nxt_opa;
        opb_q  <= nxt_opb;
        opc_q  <= dec_opc;
        sh_q   <= dec_sh;
        rd_q   <= f_rd;
        wr_q   <= dec_wr;
        ld_q   <= dec_ld;
        st_q   <= dec_st;
        br_q   <= dec_br;
        sd_q   <= dec_st ? fwd_b : 32'd0;
        insn_q <= in_insn;
        pc_q   <= in_pc;
      end
    end
  end

  assign out_valid      = valid_q;
  assign alu_opA        = opa_q;
  assign alu_opB        = opb_q;
  assign alu_opcode     = opc_q;
  assign alu_shamt      = sh_q;
  assign out_rd         = rd_q;
  assign out_wr_en      = wr_q;
  assign out_is_load    = ld_q;
  assign out_is_store   = st_q;
  assign out_is_branch  = br_q;
  assign out_store_data = sd_q;
  assign out_insn       = insn_q;
  assign out_pc         = pc_q;

endmodule

// File: tb/tb_dx_operand_stage.sv
// Bench for dx_operand_stage: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a behavioural operand-stage model.
module tb_dx_operand_stage;
  localparam bit XFWD = 1'b1;

  logic        clock = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_insn = '0, in_pc = '0;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic [31:0] x_result = '0;
  logic        m_wr_en = 1'b0, w_wr_en = 1'b0;
  logic [4:0]  m_rd = '0, w_rd = '0;
  logic [31:0] m_data = '0, w_data = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] alu_opA, alu_opB, out_store_data, out_insn, out_pc;
  logic [4:0]  alu_opcode, alu_shamt, out_rd;
  logic        out_wr_en, out_is_load, out_is_store, out_is_branch;

  logic [31:0] regs [32];
  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  dx_operand_stage #(.XFWD_EN(XFWD)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .x_result(x_result),
    .m_wr_en(m_wr_en), .m_rd(m_rd), .m_data(m_data),
    .w_wr_en(w_wr_en), .w_rd(w_rd), .w_data(w_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_store_data(out_store_data), .out_insn(out_insn), .out_pc(out_pc)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic v; logic [31:0] a, b; logic [4:0] opc, sh, rd;
    logic wr, ld, st, br; logic [31:0] sd, insn, pc;
  } mdl_t;
  mdl_t mdl = '0;

  // Register sources an instruction reads: slot 0 and slot 1, each {used, reg}.
  function automatic logic [5:0] src_of(input logic [31:0] insn, input int k);
    logic [4:0] rd, rs, rt;
    rd = insn[26:22]; rs = insn[21:17]; rt = insn[16:12];
    case (insn[31:27])
      5'd0:       return (k == 0) ? {1'b1, rs} : {1'b1, rt};
      5'd5, 5'd8: return (k == 0) ? {1'b1, rs} : 6'd0;
      5'd7:       return (k == 0) ? {1'b1, rs} : {1'b1, rd};
      5'd2, 5'd6: return (k == 0) ? {1'b1, rd} : {1'b1, rs};
      default:    return 6'd0;
    endcase
  endfunction

  // Newest-first list of in-flight writers; the first one naming s supplies the value.
  function automatic logic [31:0] value_of(input logic [4:0] s);
    logic        cv [3];
    logic [4:0]  cr [3];
    logic [31:0] cd [3];
    if (s == 0) return 32'd0;
    cv[0] = XFWD && mdl.v && mdl.wr && !mdl.ld; cr[0] = mdl.rd; cd[0] = x_result;
    cv[1] = m_wr_en; cr[1] = m_rd; cd[1] = m_data;
    cv[2] = w_wr_en; cr[2] = w_rd; cd[2] = w_data;
    for (int i = 0; i < 3; i++) if (cv[i] && cr[i] == s) return cd[i];
    return regs[s];
  endfunction

  function automatic bit m_hazard();
    logic [5:0] s;
    if (!(in_valid && mdl.v && mdl.wr && mdl.rd != 0 && (mdl.ld || !XFWD))) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      s = src_of(in_insn, k);
      if (s[5] && s[4:0] == mdl.rd) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic mdl_t predict(input logic [31:0] insn, input logic [31:0] pc);
    mdl_t e;
    logic [5:0] s0, s1;
    logic [4:0] op;
    op = insn[31:27];
    s0 = src_of(insn, 0); s1 = src_of(insn, 1);
    e = '0;
    e.v = 1'b1; e.insn = insn; e.pc = pc; e.rd = insn[26:22];
    e.a = s0[5] ? value_of(s0[4:0]) : 32'd0;
    if (op == 5'd5 || op == 5'd8 || op == 5'd7) e.b = {{15{insn[16]}}, insn[16:0]};
    else e.b = s1[5] ? value_of(s1[4:0]) : 32'd0;
    e.wr  = (op == 5'd0 || op == 5'd5 || op == 5'd8);
    e.ld  = (op == 5'd8);
    e.st  = (op == 5'd7);
    e.br  = (op == 5'd2 || op == 5'd6);
    e.opc = (op == 5'd0) ? insn[6:2] : (e.br ? 5'd1 : 5'd0);
    e.sh  = (op == 5'd0) ? insn[11:7] : 5'd0;
    e.sd  = e.st ? value_of(s1[4:0]) : 32'd0;
    return e;
  endfunction

  always @(posedge clock) begin
    if (reset) mdl = '0;
    else if (flush) mdl.v = 1'b0;
    else if (mdl.v && !out_ready) ;
    else if (m_hazard()) mdl.v = 1'b0;
    else if (in_valid) mdl = predict(in_insn, in_pc);
    else mdl.v = 1'b0;
  end

  always @(negedge clock) if (chk_en) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, !flush && (!mdl.v || out_ready) && !m_hazard()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mdl.v});
    if (mdl.v) begin
      chk("opA", alu_opA, mdl.a);
      chk("opB", alu_opB, mdl.b);
      chk("ctl", {15'd0, alu_opcode, alu_shamt, out_rd, out_wr_en, out_is_load, out_is_store, out_is_branch},
                 {15'd0, mdl.opc, mdl.sh, mdl.rd, mdl.wr, mdl.ld, mdl.st, mdl.br});
      chk("insn", out_insn, mdl.insn);
      chk("pc", out_pc, mdl.pc);
      if (mdl.st) chk("store_data", out_store_data, mdl.sd);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, aop, sh);
    return {5'd0, rd, rs, rt, sh, aop, 2'b00};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic idle(); in_valid = 0; flush = 0; out_ready = 1; m_wr_en = 0; w_wr_en = 0; tick(); endtask

  task automatic issue(input logic [31:0] insn);
    in_insn = insn; in_pc = in_pc + 4; in_valid = 1; tick(); in_valid = 0;
  endtask

  initial begin
    logic [31:0] i1, r;
    logic [4:0]  ops [8];
    ops[0] = 5'd0; ops[1] = 5'd5; ops[2] = 5'd8; ops[3] = 5'd7;
    ops[4] = 5'd2; ops[5] = 5'd6; ops[6] = 5'd1; ops[7] = 5'd31;
    for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD;
    regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd7;

    tick(); tick(); reset = 0; #1;
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", alu_opA | alu_opB | out_store_data | out_insn | out_pc, 32'd0);
    chk("rst_ctl", {15'd0, alu_opcode, alu_shamt, out_rd, out_wr_en, out_is_load, out_is_store, out_is_branch}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue(rtype(5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_opA", alu_opA, 32'd5);
    chk("add_opB", alu_opB, 32'd7);
    chk("add_rd", {27'd0, out_rd}, 32'd3);
    chk("add_wr", {31'd0, out_wr_en}, 32'd1);
    idle();

    issue(itype(5'd5, 5'd4, 5'd0, 17'd10));
    x_result = 32'd10;
    issue(rtype(5'd5, 5'd4, 5'd4, 5'd0, 5'd0));
    chk("xfwd_opA", alu_opA, 32'd10);
    chk("xfwd_opB", alu_opB, 32'd10);
    idle();

    issue(itype(5'd5, 5'd9, 5'd0, 17'h1FFFF));
    chk("sext_opB", alu_opB, 32'hFFFFFFFF);
    idle();

    issue(itype(5'd8, 5'd6, 5'd1, 17'd0));
    in_insn = rtype(5'd7, 5'd6, 5'd2, 5'd0, 5'd0); in_valid = 1; #1;
    chk("lu_stall", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    m_wr_en = 1; m_rd = 5'd6; m_data = 32'h1234; #1;
    chk("lu_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_opA", alu_opA, 32'h1234);
    idle();

    m_wr_en = 1; m_rd = 5'd8; m_data = 32'h11; w_wr_en = 1; w_rd = 5'd8; w_data = 32'h22;
    issue(rtype(5'd10, 5'd8, 5'd8, 5'd0, 5'd0));
    chk("prio_m_over_w", alu_opA, 32'h11);
    idle();

    m_wr_en = 1; m_rd = 5'd0; m_data = 32'hFF;
    issue(rtype(5'd11, 5'd0, 5'd0, 5'd0, 5'd0));
    chk("zero_reg", alu_opA, 32'd0);
    idle();

    i1 = rtype(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
    issue(i1);
    out_ready = 0; in_valid = 1; in_insn = rtype(5'd13, 5'd2, 5'd1, 5'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_opA", alu_opA, 32'd5);
      chk("bp_hold_insn", out_insn, i1);
    end
    out_ready = 1; tick(); in_valid = 0;
    chk("bp_release", alu_opA, 32'd7);
    idle();

    flush = 1; in_valid = 1; in_insn = rtype(5'd12, 5'd1, 5'd1, 5'd0, 5'd0); #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); flush = 0; in_valid = 0;
    chk("flush_drop", {31'd0, out_valid}, 32'd0);
    idle();

    issue(itype(5'd2, 5'd1, 5'd2, 17'd4));
    chk("bne_opA", alu_opA, 32'd5);
    chk("bne_opB", alu_opB, 32'd7);
    chk("bne_opc", {27'd0, alu_opcode}, 32'd1);
    chk("bne_br", {31'd0, out_is_branch}, 32'd1);
    idle();

    issue(i1); out_ready = 0; tick();
    reset = 1; tick(); reset = 0; out_ready = 1;
    chk("rst_stall_drop", {31'd0, out_valid}, 32'd0);

    for (int i = 1; i < 32; i++) regs[i] = $urandom();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom();
      in_insn   = {ops[r[2:0]], 2'b00, r[5:3], 2'b00, r[8:6], 2'b00, r[11:9], r[23:12]};
      if (r[24]) in_insn[16:12] = {r[25], 4'hF};
      in_pc     = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      x_result  = $urandom();
      m_wr_en   = $urandom_range(0, 1) == 1; m_rd = 5'($urandom_range(0, 7)); m_data = $urandom();
      w_wr_en   = $urandom_range(0, 1) == 1; w_rd = 5'($urandom_range(0, 7)); w_data = $urandom();
      regs[$urandom_range(1, 7)] = $urandom();
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
